// File: rtl/mtc_ppa_pkg.sv
// rtl/mtc_ppa_pkg.sv - shared types and helpers for the mTC-PPA pointer controller
// Purpose: FSM state encoding and the pointer wrap helper.
// Ports: none (package).
package mtc_ppa_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_PTR = 2'd2
  } state_t;

  // Widest pointer the helper handles; callers zero-extend into it and
  // truncate the result back to their own width.
  localparam int PTR_MAX_W = 32;

  // A grant at the MSB shifts the pointer out to zero; restart at bit 0.
  function automatic logic [PTR_MAX_W-1:0] ptr_wrap(input logic [PTR_MAX_W-1:0] p);
    return (p == '0) ? PTR_MAX_W'(1) : p;
  endfunction

endpackage

// File: rtl/mtc_ppa_ptr_ctrl.sv
// rtl/mtc_ppa_ptr_ctrl.sv - priority pointer owner and request issuer for the mTC-PPA arbiter
// Purpose: accepts request vectors, pairs each with the current priority
//   pointer, issues both to the arbiter core, then waits for the next
//   pointer (or a round-done pulse) before accepting another request.
// Ports:
//   clk, reset                     clock, async active-high reset
//   in_req_i/_vld_i/_rdy_o         upstream request channel
//   out_req_o/out_ptr_o/_vld_o/_rdy_i  issue channel to arbiter core
//   in_ptr_next_i/_vld_i/_rdy_o    next-pointer channel from hptr mux
//   in_round_done_i                round finished without pointer update
//   ptr_o, busy_o, round_cnt_o     status
module mtc_ppa_ptr_ctrl
  import mtc_ppa_pkg::*;
#(
  parameter int WIDTH_N = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH_N-1:0] in_req_i,
  input  logic               in_req_vld_i,
  output logic               in_req_rdy_o,
  output logic [WIDTH_N-1:0] out_req_o,
  output logic [WIDTH_N-1:0] out_ptr_o,
  output logic               out_req_vld_o,
  input  logic               out_req_rdy_i,
  input  logic [WIDTH_N-1:0] in_ptr_next_i,
  input  logic               in_ptr_next_vld_i,
  output logic               in_ptr_next_rdy_o,
  input  logic               in_round_done_i,
  output logic [WIDTH_N-1:0] ptr_o,
  output logic               busy_o,
  output logic [CNT_W-1:0]   round_cnt_o
);

  state_t             state_q, state_d;
  logic               alive_q;
  logic [WIDTH_N-1:0] req_q;
  logic [WIDTH_N-1:0] ptr_q;
  logic [CNT_W-1:0]   cnt_q;

  logic req_hs, ptr_hs, done_ev, req_nonzero;
  logic [WIDTH_N-1:0] ptr_next_wrapped;

  assign req_hs      = in_req_rdy_o & in_req_vld_i;
  assign req_nonzero = (in_req_i != '0);
  assign ptr_hs      = in_ptr_next_rdy_o & in_ptr_next_vld_i;
  assign done_ev     = (state_q == WAIT_PTR) & in_round_done_i;

  assign ptr_next_wrapped = WIDTH_N'(ptr_wrap(PTR_MAX_W'(in_ptr_next_i)));

  // Next-state and state-decoded outputs. alive_q keeps in_req_rdy_o low
  // while reset is held and releases it on the first clock afterwards,
  // without a combinational path from the reset pin.
  always_comb begin
    state_d           = state_q;
    in_req_rdy_o      = 1'b0;
    out_req_vld_o     = 1'b0;
    in_ptr_next_rdy_o = 1'b0;
    busy_o            = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_req_rdy_o = alive_q;
        if (req_hs && req_nonzero) state_d = ISSUE;
      end
      ISSUE: begin
        out_req_vld_o = 1'b1;
        busy_o        = 1'b1;
        if (out_req_rdy_i) state_d = WAIT_PTR;
      end
      WAIT_PTR: begin
        in_ptr_next_rdy_o = 1'b1;
        busy_o            = 1'b1;
        if (in_ptr_next_vld_i || in_round_done_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      alive_q <= 1'b0;
      req_q   <= '0;
      ptr_q   <= WIDTH_N'(1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
      if (req_hs && req_nonzero) req_q <= in_req_i;
      // Pointer update wins over round_done; either ends the round once.
      if (ptr_hs) ptr_q <= ptr_next_wrapped;
      if (ptr_hs || done_ev) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_req_o   = req_q;
  assign out_ptr_o   = ptr_q;
  assign ptr_o       = ptr_q;
  assign round_cnt_o = cnt_q;

endmodule

// File: tb/tb_mtc_ppa_ptr_ctrl.sv
// tb/tb_mtc_ppa_ptr_ctrl.sv - randomized scoreboard bench for mtc_ppa_ptr_ctrl
module tb_mtc_ppa_ptr_ctrl;

  localparam int W  = 4;
  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_req;
  logic         in_req_vld;
  logic         in_req_rdy;
  logic [W-1:0] out_req;
  logic [W-1:0] out_ptr;
  logic         out_req_vld;
  logic         out_req_rdy;
  logic [W-1:0] in_ptr_next;
  logic         in_ptr_next_vld;
  logic         in_ptr_next_rdy;
  logic         in_round_done;
  logic [W-1:0] ptr;
  logic         busy;
  logic [CW-1:0] round_cnt;

  mtc_ppa_ptr_ctrl #(.WIDTH_N(W), .CNT_W(CW)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_req_i          (in_req),
    .in_req_vld_i      (in_req_vld),
    .in_req_rdy_o      (in_req_rdy),
    .out_req_o         (out_req),
    .out_ptr_o         (out_ptr),
    .out_req_vld_o     (out_req_vld),
    .out_req_rdy_i     (out_req_rdy),
    .in_ptr_next_i     (in_ptr_next),
    .in_ptr_next_vld_i (in_ptr_next_vld),
    .in_ptr_next_rdy_o (in_ptr_next_rdy),
    .in_round_done_i   (in_round_done),
    .ptr_o             (ptr),
    .busy_o            (busy),
    .round_cnt_o       (round_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] req;
    logic [W-1:0] ptr;
  } iss_t;

  typedef struct {
    logic [W-1:0]  ptr;
    logic [CW-1:0] cnt;
  } done_t;

  typedef enum {M_IDLE, M_ISSUE, M_WAIT} mph_t;

  iss_t  iq[$];
  done_t dq[$];

  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;
  bit   pend   = 1'b0;
  mph_t mph    = M_IDLE;
  mph_t cur_ph = M_IDLE;
  int   mptr   = 1;
  int   mcnt   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic queue_miss(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=queue-empty expected=entry @%0t", name, $time);
  endtask

  // Drive one cycle of random stimulus at the falling edge and advance the
  // protocol model to where the next rising edge leaves it.
  task automatic step();
    int r;
    cur_ph      = mph;
    in_req_vld  = ($urandom_range(0, 9) < 4);
    in_req      = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    out_req_rdy = ($urandom_range(0, 9) < 4);
    if (mph == M_WAIT) r = $urandom_range(0, 3);
    else r = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
    in_ptr_next_vld = (r % 2) == 1;
    in_round_done   = r >= 2;
    in_ptr_next     = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    case (mph)
      M_IDLE: begin
        if (in_req_vld && in_req != 0) begin
          iq.push_back('{req: in_req, ptr: W'(mptr)});
          mph = M_ISSUE;
        end
      end
      M_ISSUE: if (out_req_rdy) mph = M_WAIT;
      M_WAIT: begin
        if (in_ptr_next_vld || in_round_done) begin
          if (in_ptr_next_vld) mptr = (in_ptr_next == 0) ? 1 : int'(in_ptr_next);
          mcnt = (mcnt + 1) % (1 << CW);
          dq.push_back('{ptr: W'(mptr), cnt: CW'(mcnt)});
          mph = M_IDLE;
        end
      end
      default: mph = M_IDLE;
    endcase
  endtask

  // Monitor: checks the DUT's view against the model phase and pops the
  // scoreboard queues whenever the DUT presents an issue or ends a round.
  always @(negedge clk) begin : monitor
    done_t d;
    if (mon_en) begin
      #2;
      if (pend) begin
        pend = 1'b0;
        if (dq.size() == 0) queue_miss("round_q");
        else begin
          d = dq.pop_front();
          chk("ptr_after_round", 32'(ptr), 32'(d.ptr));
          chk("cnt_after_round", 32'(round_cnt), 32'(d.cnt));
        end
      end
      chk("in_req_rdy", 32'(in_req_rdy), 32'(cur_ph == M_IDLE));
      chk("busy", 32'(busy), 32'(cur_ph != M_IDLE));
      chk("ptr_next_rdy", 32'(in_ptr_next_rdy), 32'(cur_ph == M_WAIT));
      chk("out_req_vld", 32'(out_req_vld), 32'(cur_ph == M_ISSUE));
      if (out_req_vld) begin
        if (iq.size() == 0) queue_miss("issue_q");
        else begin
          chk("out_req", 32'(out_req), 32'(iq[0].req));
          chk("out_ptr", 32'(out_ptr), 32'(iq[0].ptr));
          if (out_req_rdy) void'(iq.pop_front());
        end
      end
      if (in_ptr_next_rdy && (in_ptr_next_vld || in_round_done)) pend = 1'b1;
    end
  end

  initial begin
    bit got;
    reset           = 1'b1;
    in_req          = '0;
    in_req_vld      = 1'b0;
    out_req_rdy     = 1'b0;
    in_ptr_next     = '0;
    in_ptr_next_vld = 1'b0;
    in_round_done   = 1'b0;

    #2;
    chk("rst_in_req_rdy", 32'(in_req_rdy), 32'd0);
    chk("rst_out_req_vld", 32'(out_req_vld), 32'd0);
    chk("rst_ptr_next_rdy", 32'(in_ptr_next_rdy), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ptr", 32'(ptr), 32'd1);
    chk("rst_cnt", 32'(round_cnt), 32'd0);

    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #2;
    chk("rdy_after_release", 32'(in_req_rdy), 32'd1);

    @(negedge clk);
    mon_en = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      step();
      @(negedge clk);
    end

    // Steer into WAIT_PTR, then hit it with an asynchronous reset mid-cycle.
    got = 1'b0;
    for (int g = 0; g < 400; g++) begin
      step();
      if (mph == M_WAIT) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      bad++;
      total++;
      $display("FAIL reach_wait actual=timeout expected=WAIT_PTR @%0t", $time);
    end
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    in_req_vld      = 1'b0;
    in_round_done   = 1'b0;
    in_ptr_next     = 4'b0100;
    in_ptr_next_vld = 1'b1;
    chk("wait_busy", 32'(busy), 32'd1);
    chk("wait_ptr_next_rdy", 32'(in_ptr_next_rdy), 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ptr", 32'(ptr), 32'd1);
    chk("arst_ptr_next_rdy", 32'(in_ptr_next_rdy), 32'd0);
    chk("arst_in_req_rdy", 32'(in_req_rdy), 32'd0);
    chk("arst_cnt", 32'(round_cnt), 32'd0);
    iq.delete();
    dq.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #2;
    chk("post_arst_ptr", 32'(ptr), 32'd1);
    chk("post_arst_cnt", 32'(round_cnt), 32'd0);
    chk("post_arst_in_req_rdy", 32'(in_req_rdy), 32'd1);
    chk("post_arst_ptr_next_rdy", 32'(in_ptr_next_rdy), 32'd0);
    @(posedge clk);
    #2;
    chk("pending_ptr_not_taken", 32'(ptr), 32'd1);
    chk("pending_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
